// File: rtl/ps2_ascii_fifo_decoder_if.sv
// rtl/ps2_ascii_fifo_decoder_if.sv - byte-in / word-out bundle for the PS/2 ASCII decoder (width of mods follows PS2_RELEASE_EVENT_EN)
interface ps2_ascii_fifo_decoder_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
);
`ifdef PS2_RELEASE_EVENT_EN
    localparam int MODS_W = 4;
`else
    localparam int MODS_W = 3;
`endif

    logic              code_valid;
    logic [7:0]        code;
    logic              out_valid;
    logic              out_ready;
    logic [6:0]        out_ascii;
    logic [MODS_W-1:0] out_mods;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic              ovf_clr;
    logic              caps_lock;

    // Receiver/consumer side
    modport master (
        output code_valid, code, out_ready, ovf_clr,
        input  out_valid, out_ascii, out_mods, level, overflow, caps_lock
    );

    // Decoder side
    modport slave (
        input  code_valid, code, out_ready, ovf_clr,
        output out_valid, out_ascii, out_mods, level, overflow, caps_lock
    );
endinterface

// File: rtl/ps2_ascii_fifo_decoder.sv
// rtl/ps2_ascii_fifo_decoder.sv - PS/2 set-2 to ASCII translator with output FIFO; PS2_RELEASE_EVENT_EN adds release words
module ps2_ascii_fifo_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    ps2_ascii_fifo_decoder_if.slave bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef PS2_RELEASE_EVENT_EN
    localparam int  MODS_W  = 4;
    localparam bit  REL_EN  = 1'b1;
`else
    localparam int  MODS_W  = 3;
    localparam bit  REL_EN  = 1'b0;
`endif
    localparam int WORD_W = 7 + MODS_W;

    // Lowercase letter lookup: {hit, ascii}
    function automatic logic [7:0] letter_lc(input logic [7:0] c);
        logic [7:0] r;
        r = 8'h00;
        case (c)
            8'h1C: r = {1'b1, 7'h61};
            8'h32: r = {1'b1, 7'h62};
            8'h21: r = {1'b1, 7'h63};
            8'h23: r = {1'b1, 7'h64};
            8'h24: r = {1'b1, 7'h65};
            8'h2B: r = {1'b1, 7'h66};
            8'h34: r = {1'b1, 7'h67};
            8'h33: r = {1'b1, 7'h68};
            8'h43: r = {1'b1, 7'h69};
            8'h3B: r = {1'b1, 7'h6A};
            8'h42: r = {1'b1, 7'h6B};
            8'h4B: r = {1'b1, 7'h6C};
            8'h3A: r = {1'b1, 7'h6D};
            8'h31: r = {1'b1, 7'h6E};
            8'h44: r = {1'b1, 7'h6F};
            8'h4D: r = {1'b1, 7'h70};
            8'h15: r = {1'b1, 7'h71};
            8'h2D: r = {1'b1, 7'h72};
            8'h1B: r = {1'b1, 7'h73};
            8'h2C: r = {1'b1, 7'h74};
            8'h3C: r = {1'b1, 7'h75};
            8'h2A: r = {1'b1, 7'h76};
            8'h1D: r = {1'b1, 7'h77};
            8'h22: r = {1'b1, 7'h78};
            8'h35: r = {1'b1, 7'h79};
            8'h1A: r = {1'b1, 7'h7A};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Digits, US punctuation and fixed control keys: {hit, ascii}
    function automatic logic [7:0] sym_char(input logic [7:0] c, input logic sh);
        logic [7:0] r;
        r = 8'h00;
        case (c)
            8'h16: r = {1'b1, sh ? 7'h21 : 7'h31};
            8'h1E: r = {1'b1, sh ? 7'h40 : 7'h32};
            8'h26: r = {1'b1, sh ? 7'h23 : 7'h33};
            8'h25: r = {1'b1, sh ? 7'h24 : 7'h34};
            8'h2E: r = {1'b1, sh ? 7'h25 : 7'h35};
            8'h36: r = {1'b1, sh ? 7'h5E : 7'h36};
            8'h3D: r = {1'b1, sh ? 7'h26 : 7'h37};
            8'h3E: r = {1'b1, sh ? 7'h2A : 7'h38};
            8'h46: r = {1'b1, sh ? 7'h28 : 7'h39};
            8'h45: r = {1'b1, sh ? 7'h29 : 7'h30};
            8'h4E: r = {1'b1, sh ? 7'h5F : 7'h2D};
            8'h55: r = {1'b1, sh ? 7'h2B : 7'h3D};
            8'h54: r = {1'b1, sh ? 7'h7B : 7'h5B};
            8'h5B: r = {1'b1, sh ? 7'h7D : 7'h5D};
            8'h5D: r = {1'b1, sh ? 7'h7C : 7'h5C};
            8'h4C: r = {1'b1, sh ? 7'h3A : 7'h3B};
            8'h52: r = {1'b1, sh ? 7'h22 : 7'h27};
            8'h41: r = {1'b1, sh ? 7'h3C : 7'h2C};
            8'h49: r = {1'b1, sh ? 7'h3E : 7'h2E};
            8'h4A: r = {1'b1, sh ? 7'h3F : 7'h2F};
            8'h0E: r = {1'b1, sh ? 7'h7E : 7'h60};
            8'h29: r = {1'b1, 7'h20};
            8'h66: r = {1'b1, 7'h08};
            8'h0D: r = {1'b1, 7'h09};
            8'h5A: r = {1'b1, 7'h0D};
            8'h76: r = {1'b1, 7'h1B};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic             e0, brk;
    logic [2:0]       skip_cnt;
    logic             shift_l, shift_r, ctrl_l, ctrl_r;
    logic             caps_lock_r, caps_held;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              overflow_r;

    logic       shift, ctrl;
    logic       accept, is_prefix, is_mod, final_byte;
    logic [7:0] lt, sy;
    logic       xl_hit;
    logic [6:0] xl_ascii;
    logic       push_req, push_ok, pop, full, ovf_evt;
    logic [WORD_W-1:0] push_word;

    assign shift = shift_l | shift_r;
    assign ctrl  = ctrl_l | ctrl_r;

    // Classify the incoming byte and translate it using the pre-update modifier state
    always_comb begin
        accept     = bus.code_valid && (skip_cnt == 3'd0);
        is_prefix  = (bus.code == 8'hE0) || (bus.code == 8'hF0) || (bus.code == 8'hE1);
        is_mod     = (bus.code == 8'h12) || (bus.code == 8'h59) ||
                     (bus.code == 8'h14) || (bus.code == 8'h58);
        final_byte = accept && !is_prefix;
        lt         = letter_lc(bus.code);
        sy         = sym_char(bus.code, shift);
        xl_hit     = 1'b0;
        xl_ascii   = 7'h00;
        if (e0) begin
            if (bus.code == 8'h71 && !ctrl) begin
                xl_hit   = 1'b1;
                xl_ascii = 7'h7F;
            end
        end else if (lt[7]) begin
            xl_hit = 1'b1;
            if (ctrl)
                xl_ascii = lt[6:0] & 7'h1F;
            else if (shift ^ caps_lock_r)
                xl_ascii = lt[6:0] & 7'h5F;
            else
                xl_ascii = lt[6:0];
        end else if (sy[7] && !ctrl) begin
            xl_hit   = 1'b1;
            xl_ascii = sy[6:0];
        end
        push_req = final_byte && !is_mod && xl_hit && (!brk || REL_EN);
`ifdef PS2_RELEASE_EVENT_EN
        push_word = {brk, ctrl, shift, caps_lock_r, xl_ascii};
`else
        push_word = {ctrl, shift, caps_lock_r, xl_ascii};
`endif
    end

    assign full    = (count == LVL_W'(FIFO_DEPTH));
    assign pop     = (count != '0) && bus.out_ready;
    assign push_ok = push_req && (!full || pop);
    assign ovf_evt = push_req && full && !pop;

    // Prefix tracking, Pause skipping and modifier/Caps Lock state
    always_ff @(posedge clk) begin
        if (rst) begin
            e0          <= 1'b0;
            brk         <= 1'b0;
            skip_cnt    <= 3'd0;
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            ctrl_l      <= 1'b0;
            ctrl_r      <= 1'b0;
            caps_lock_r <= 1'b0;
            caps_held   <= 1'b0;
        end else if (bus.code_valid) begin
            if (skip_cnt != 3'd0) begin
                skip_cnt <= skip_cnt - 3'd1;
            end else if (bus.code == 8'hE1) begin
                skip_cnt <= 3'd7;
                e0       <= 1'b0;
                brk      <= 1'b0;
            end else if (bus.code == 8'hE0) begin
                e0 <= 1'b1;
            end else if (bus.code == 8'hF0) begin
                brk <= 1'b1;
            end else begin
                case (bus.code)
                    8'h12: shift_l <= !brk;
                    8'h59: shift_r <= !brk;
                    8'h14: begin
                        if (e0) ctrl_r <= !brk;
                        else    ctrl_l <= !brk;
                    end
                    8'h58: begin
                        if (brk) begin
                            caps_held <= 1'b0;
                        end else if (!caps_held) begin
                            caps_lock_r <= !caps_lock_r;
                            caps_held   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                e0  <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (ovf_evt)          overflow_r <= 1'b1;
            else if (bus.ovf_clr) overflow_r <= 1'b0;
        end
    end

    // FIFO storage; stale entries are masked by the occupancy count
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_ascii = bus.out_valid ? mem[rd_ptr][6:0] : 7'h00;
    assign bus.out_mods  = bus.out_valid ? mem[rd_ptr][WORD_W-1:7] : '0;
    assign bus.level     = count;
    assign bus.overflow  = overflow_r;
    assign bus.caps_lock = caps_lock_r;
endmodule
